signal_conditioner: RTL and testbench
=====================================

Name: signal_conditioner

Overview:
Front-end stage directly upstream of frequency_counter; drives its signal_input from the raw external signal.
- Synchronises the asynchronous signal into clk_i, optionally rejects glitches, and qualifies edges by polarity.
- Applies a programmable prescaler to the qualified edges.
- Outputs a one-cycle edge strobe, a divided square wave and an activity flag; the counter consumes the square wave or strobe.

Parameters:
SYNC_STAGES, 2, synchroniser flops (legal range 2..4)
FILTER_LEN, 3, consecutive stable samples needed before the filtered level changes (1..15)
TIMEOUT_CYCLES, 1024, clk_i cycles without a qualified edge before signal_present_o drops
PRESCALE_W, 8, width of prescale_i

Ports:
clk_i  input  1  system clock; all logic on its rising edge
rst_i  input  1  asynchronous, active-high reset
signal_raw_i  input  1  raw asynchronous input signal
enable_i  input  1  1 = conditioning active
edge_sel_i  input  2  00 rising, 01 falling, 10 both, 11 none
prescale_i  input  PRESCALE_W  divide ratio N; 0 and 1 both mean divide-by-1
edge_pulse_o  output  1  one-cycle strobe on every Nth qualified edge
signal_out_o  output  1  toggles on each edge_pulse_o (f_out = f_edges/(2N))
signal_present_o  output  1  qualified edge seen within last TIMEOUT_CYCLES
filt_level_o  output  1  current synchronised/filtered level, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - All flops 0.
  - edge_pulse_o=0, signal_out_o=0, signal_present_o=0, filt_level_o=0.
  - Prescale counter 0; timeout counter 0.
- Synchroniser: SYNC_STAGES-flop chain.
  - Runs regardless of enable_i.
- Filter (with macro):
  - filt_level updates only after the synchronised value differs from filt_level for FILTER_LEN consecutive cycles.
  - The stability counter clears on any sample equal to filt_level.
  - Runs regardless of enable_i, so re-enable never produces a false edge.
- Edge detect:
  - Rising = filt_level 0→1; falling = 1→0; selection per edge_sel_i.
  - 11 produces no qualified edges.
  - edge_sel_i is sampled every cycle (combinational qualify, registered output).
- Latency: raw transition to edge_pulse_o with N=1 is SYNC_STAGES+FILTER_LEN+1 clk_i cycles.
  - Without the filter it is SYNC_STAGES+1.
  - Measured from the first rising clk_i edge that samples the new raw level.
- Prescaler:
  - N latched from prescale_i while enable_i=0, and on every terminal count.
  - Counter increments on each qualified edge; at count N-1 it emits edge_pulse_o, returns to 0, and re-latches N.
  - Mid-cycle prescale_i changes therefore take effect only after the current period completes.
- signal_out_o: registered, toggles in the same cycle edge_pulse_o is asserted.
- enable_i=0:
  - Prescale counter held 0; edge_pulse_o forced 0; signal_out_o cleared to 0.
  - Timeout counter cleared; signal_present_o=0.
- Activity timeout:
  - Counter reloads to 0 on every qualified edge (pre-prescaler); signal_present_o goes 1 that cycle.
  - Otherwise the counter increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, signal_present_o goes 0.
- Simultaneous events:
  - Qualified edge in the same cycle enable_i falls: disable wins, no pulse.
  - Qualified edge on the cycle the timeout saturates: edge wins, signal_present_o stays 1.
- Reset mid-operation: immediate return to reset values; the first edge after release is judged against filt_level=0.
  - A raw level held 1 through reset yields a rising edge after the sync+filter latency.

Optional Feature:
SIGCOND_GLITCH_FILTER_EN
- Defined: filter stage present as above; FILTER_LEN effective.
- Undefined: filt_level equals the last synchroniser flop, FILTER_LEN is ignored, and latency reduces to SYNC_STAGES+1.

Test Plan:
- Reset then release, raw held 0, enable_i=1 -> all outputs 0; signal_present_o 0 after 1024 cycles.
- Filter on, FILTER_LEN=3, clk 10 ns, edge_sel=00, N=1, raw 80 ns period square wave -> one edge_pulse_o per raw rising edge, 6 cycles after the sampling edge; signal_out_o period 160 ns.
- Filter on, FILTER_LEN=3, raw 20 ns high glitch -> no edge_pulse_o, filt_level_o stays 0; a 40 ns high pulse -> exactly one pulse.
- edge_sel=10, N=4, 8 raw periods -> 16 qualified edges, 4 edge_pulse_o; signal_out_o toggles 4 times; prescale_i changed to 2 after the 1st pulse -> new ratio applies only after the 2nd pulse.
- Drop enable_i for 5 cycles mid-count, then raise it -> prescale count restarts at 0, signal_out_o=0, no spurious pulse on re-enable.
- Stop raw toggling with enable_i=1 -> signal_present_o falls exactly 1024 cycles after the last qualified edge; it rises again on the next edge.

Source files
------------

// File: rtl/signal_conditioner.sv
// signal_conditioner: front end for frequency_counter. Synchronises a raw
// asynchronous input, optionally de-glitches it, qualifies edges by polarity,
// prescales them and produces a strobe, a divided square wave and an activity flag.
// Latency: raw change to edge_pulse_o (N=1) is SYNC_STAGES+FILTER_LEN+1 cycles with
// the glitch filter, SYNC_STAGES+1 without. No backpressure: outputs are free-running.
//
// Optional feature macro: SIGCOND_GLITCH_FILTER_EN (defined = glitch filter present).
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   signal_raw_i     raw asynchronous input
//   enable_i         1 = conditioning active
//   edge_sel_i       00 rising, 01 falling, 10 both, 11 none
//   prescale_i       divide ratio N (0 and 1 mean divide-by-1)
//   edge_pulse_o     one-cycle strobe on every Nth qualified edge
//   signal_out_o     toggles with each edge_pulse_o
//   signal_present_o qualified edge seen within the last TIMEOUT_CYCLES
//   filt_level_o     synchronised/filtered level (debug)

module signal_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PRESCALE_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  signal_raw_i,
  input  logic                  enable_i,
  input  logic [1:0]            edge_sel_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  edge_pulse_o,
  output logic                  signal_out_o,
  output logic                  signal_present_o,
  output logic                  filt_level_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  // Elaboration-time guard on the legal parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_param
    $error("signal_conditioner: SYNC_STAGES or FILTER_LEN out of range");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser (runs regardless of enable_i)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_raw_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Glitch filter: level follows the synchronised value only after it has
  // disagreed for FILTER_LEN consecutive samples. Kept running while disabled
  // so that re-enabling never sees a stale level step.
  // ---------------------------------------------------------------------------
  logic filt_level;

`ifdef SIGCOND_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] stab_cnt;
  logic          filt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stab_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (sync_out != filt_q) begin
      if (stab_cnt == FW'(FILTER_LEN - 1)) begin
        filt_q   <= sync_out;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + FW'(1);
      end
    end else begin
      stab_cnt <= '0;
    end
  end

  assign filt_level = filt_q;
`else
  assign filt_level = sync_out;
`endif

  assign filt_level_o = filt_level;

  // ---------------------------------------------------------------------------
  // Edge qualification (combinational on the current edge_sel_i)
  // ---------------------------------------------------------------------------
  logic filt_prev;
  logic rise;
  logic fall;
  logic qual;

  assign rise = filt_level & ~filt_prev;
  assign fall = ~filt_level & filt_prev;

  always_comb begin
    qual = 1'b0;
    case (edge_sel_i)
      2'b00:   qual = rise;
      2'b01:   qual = fall;
      2'b10:   qual = rise | fall;
      default: qual = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler, square-wave output and activity timeout
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] n_q;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [TW-1:0]         tcnt;
  logic                  term;

  // N of 0 or 1 both divide by one, so every qualified edge is terminal.
  assign term = (n_q <= PRESCALE_W'(1)) ? (pre_cnt == '0)
                                        : (pre_cnt == n_q - PRESCALE_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_prev        <= 1'b0;
      n_q              <= '0;
      pre_cnt          <= '0;
      tcnt             <= '0;
      edge_pulse_o     <= 1'b0;
      signal_out_o     <= 1'b0;
      signal_present_o <= 1'b0;
    end else begin
      filt_prev <= filt_level;
      if (!enable_i) begin
        // Disable dominates any edge arriving in the same cycle.
        n_q              <= prescale_i;
        pre_cnt          <= '0;
        tcnt             <= '0;
        edge_pulse_o     <= 1'b0;
        signal_out_o     <= 1'b0;
        signal_present_o <= 1'b0;
      end else begin
        edge_pulse_o <= 1'b0;
        if (qual) begin
          if (term) begin
            // Ratio is re-latched only here, so a mid-period prescale_i change
            // waits for the current period to finish.
            pre_cnt      <= '0;
            n_q          <= prescale_i;
            edge_pulse_o <= 1'b1;
            signal_out_o <= ~signal_out_o;
          end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
          end
          // An edge on the saturation cycle still wins.
          tcnt             <= '0;
          signal_present_o <= 1'b1;
        end else if (tcnt != TMAX) begin
          tcnt <= tcnt + TW'(1);
          if (tcnt == TMAX - TW'(1)) begin
            signal_present_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_conditioner.sv
// Testbench for signal_conditioner: directed scenarios plus randomized raw
// stimulus, checked every cycle against an event-level reference model.
// Outputs are sampled 1 time unit after each rising clock edge.

module tb_signal_conditioner;

  localparam int S  = 2;
  localparam int F  = 3;
  localparam int T  = 1024;
  localparam int PW = 8;
`ifdef SIGCOND_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = S + F + 1;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = S + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          raw = 1'b0;
  logic          en  = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [PW-1:0] pre = 8'd1;
  logic          edge_pulse;
  logic          sig_out;
  logic          present;
  logic          filt_level;

  signal_conditioner #(
    .SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .PRESCALE_W(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .signal_raw_i(raw), .enable_i(en),
    .edge_sel_i(sel), .prescale_i(pre),
    .edge_pulse_o(edge_pulse), .signal_out_o(sig_out),
    .signal_present_o(present), .filt_level_o(filt_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: history of raw samples, filtered level after the
  // last two edges, consecutive-disagreement run, edges in current period.
  bit rq[$];
  bit lvl_a, lvl_b;
  int run;
  int ecnt;
  int nl;
  bit m_pulse, m_so, m_pres, had;
  int since;

  // Observation counters for directed scenarios.
  int  obs_pulses;
  int  obs_toggles;
  bit  last_so;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    rq.delete();
    lvl_a = 0; lvl_b = 0; run = 0; ecnt = 0; nl = 0;
    m_pulse = 0; m_so = 0; m_pres = 0; had = 0; since = 0;
  endfunction

  function automatic void model_edge();
    bit q, d, newl;
    int nn;
    rq.push_front(raw);
    case (sel)
      2'b00:   q = lvl_a & ~lvl_b;
      2'b01:   q = ~lvl_a & lvl_b;
      2'b10:   q = lvl_a ^ lvl_b;
      default: q = 0;
    endcase
    if (!en) begin
      ecnt = 0; nl = int'(pre); m_pulse = 0; m_so = 0;
      had = 0; since = 0; m_pres = 0;
    end else begin
      m_pulse = 0;
      if (q) begin
        had = 1; since = 0;
        ecnt++;
        nn = (nl <= 1) ? 1 : nl;
        if (ecnt >= nn) begin
          m_pulse = 1; m_so = ~m_so; ecnt = 0; nl = int'(pre);
        end
      end else if (since < T) begin
        since++;
      end
      m_pres = had && (since < T);
    end
`ifdef SIGCOND_GLITCH_FILTER_EN
    d = (rq.size() > S) ? rq[S] : 1'b0;
    newl = lvl_a;
    if (d != lvl_a) begin
      run++;
      if (run >= F) begin
        newl = d; run = 0;
      end
    end else begin
      run = 0;
    end
`else
    d = 1'b0;
    newl = (rq.size() > S - 1) ? rq[S-1] : 1'b0;
`endif
    lvl_b = lvl_a;
    lvl_a = newl;
    while (rq.size() > S + 1) void'(rq.pop_back());
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("edge_pulse", edge_pulse, m_pulse);
    chk("signal_out", sig_out, m_so);
    chk("present", present, m_pres);
    chk("filt_level", filt_level, lvl_a);
    obs_pulses += int'(edge_pulse);
    if (sig_out != last_so) obs_toggles++;
    last_so = sig_out;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pulse", edge_pulse, 1'b0);
    chk("rst_out", sig_out, 1'b0);
    chk("rst_present", present, 1'b0);
    chk("rst_filt", filt_level, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    last_so = 1'b0;
  endtask

  task automatic clear_obs();
    obs_pulses = 0;
    obs_toggles = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    bit first;
    int len;

    model_reset();
    clear_obs();
    last_so = 0;
    en = 1; raw = 0; sel = 2'b00; pre = 8'd1;
    do_reset();

    // Idle with raw low: nothing ever qualifies, present never rises.
    steps(1100);
    chk("idle_present", present, 1'b0);

    // Latency from first sampling edge to strobe.
    en = 0; step(); en = 1;
    raw = 0; steps(20);
    raw = 1; n = 0;
    while (n < 40) begin
      step(); n++;
      if (edge_pulse) break;
    end
    chk_int("latency", n, LAT);

    // 80 ns square wave, rising edges, N=1: one strobe per period.
    raw = 0; steps(12); clear_obs();
    for (int p = 0; p < 5; p++) begin
      raw = 1; steps(4);
      raw = 0; steps(4);
    end
    steps(10);
    chk_int("square_pulses", obs_pulses, 5);
    chk_int("square_toggles", obs_toggles, 5);

    // 2-cycle glitch is rejected by the filter; 4-cycle pulse is not.
    raw = 0; steps(12); clear_obs();
    raw = 1; steps(2);
    raw = 0; steps(12);
    chk_int("glitch_pulses", obs_pulses, FILT ? 0 : 1);
    clear_obs();
    raw = 1; steps(4);
    raw = 0; steps(12);
    chk_int("wide_pulses", obs_pulses, 1);

    // Both edges, N=4, 8 periods: 16 edges -> 4 strobes.
    sel = 2'b10; pre = 8'd4;
    en = 0; step(); en = 1; clear_obs();
    for (int p = 0; p < 8; p++) begin
      raw = 1; steps(4);
      raw = 0; steps(4);
    end
    steps(12);
    chk_int("div4_pulses", obs_pulses, 4);
    chk_int("div4_toggles", obs_toggles, 4);

    // Ratio changed to 2 after the first strobe applies after the second:
    // strobes at edges 4, 8, 10, ..., 20.
    pre = 8'd4; en = 0; step(); en = 1; clear_obs(); first = 1;
    for (int h = 0; h < 20; h++) begin
      raw = ~raw;
      for (int k = 0; k < 4; k++) begin
        step();
        if (first && edge_pulse) begin
          pre = 8'd2; first = 0;
        end
      end
    end
    steps(12);
    chk_int("ratio_change_pulses", obs_pulses, 8);

    // Disable mid-count: count restarts, output cleared, no spurious strobe.
    pre = 8'd4; en = 0; step(); en = 1;
    raw = 0; steps(8);
    raw = 1; steps(8);
    raw = 0; steps(8);
    en = 0; steps(5);
    chk("disabled_out", sig_out, 1'b0);
    chk("disabled_present", present, 1'b0);
    en = 1; clear_obs();
    raw = 1; steps(8);
    raw = 0; steps(8);
    raw = 1; steps(8);
    steps(8);
    chk_int("reenable_restart", obs_pulses, 0);
    raw = 0; steps(8);
    chk_int("reenable_fourth", obs_pulses, 1);

    // Randomized raw, selection, ratio, enable and occasional reset.
    for (int it = 0; it < 600; it++) begin
      len = $urandom_range(1, 6);
      raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) pre = PW'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 149) == 0) do_reset();
      steps(len);
    end

    // Activity timeout: present falls exactly T cycles after the last edge.
    sel = 2'b00; en = 0; step(); en = 1;
    raw = 0; steps(10);
    raw = 1; n = 0;
    while (n < 40) begin
      step(); n++;
      if (present) break;
    end
    chk_int("present_rise", n, LAT);
    c = 0;
    while (c < 1200) begin
      step(); c++;
      if (!present) break;
    end
    chk_int("timeout_len", c, T);
    sel = 2'b10; raw = 0; n = 0;
    while (n < 40) begin
      step(); n++;
      if (present) break;
    end
    chk_int("present_again", n, LAT);

    // Raw held high through reset yields a rising edge after release.
    sel = 2'b00; pre = 8'd1; raw = 1;
    do_reset();
    n = 0;
    while (n < 40) begin
      step(); n++;
      if (edge_pulse) break;
    end
    chk_int("reset_raw_high", n, LAT);
    steps(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
